// File: rtl/arbiter_wrr.sv
// -----------------------------------------------------------------------------
// arbiter_wrr -- weighted round-robin arbiter
//
// Grants one of WIDTH requesters and keeps the grant for the owner's weight
// (its quantum) in consecutive cycles. When the quantum ends, the grant moves
// on in round-robin order. The next grant is also available combinationally,
// so a bus master can decode it one cycle early.
//
// Optional feature (compile-time macro ARB_LOCK_EN):
//   When the macro is defined, a `lock` input is added. While lock is high
//   and the owner still requests, the grant is held and the credit counter
//   is frozen.
//
// Parameters
//   WIDTH   number of requesters (>= 2)
//   WGTW    bits per weight field
//   BITW    index width, ceil(log2(WIDTH))
//
// Ports
//   clk      in   1            clock; all state changes on the rising edge
//   rst_n    in   1            asynchronous active-low reset
//   req      in   WIDTH        level requests, one bit per requester
//   weight   in   WIDTH*WGTW   quantum of requester i at [i*WGTW +: WGTW]
//   lock     in   1            (ARB_LOCK_EN only) extends the current grant
//   grt      out  WIDTH        registered one-hot grant, or zero
//   id       out  BITW+1       registered {valid, index} of grt
//   pre_grt  out  WIDTH        combinational value grt takes at the next edge
//   pre_id   out  BITW+1       combinational {valid, index} of pre_grt
// -----------------------------------------------------------------------------
module arbiter_wrr #(
   parameter int WIDTH = 32,
   parameter int WGTW  = 4,
   parameter int BITW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       req,
   input  logic [WIDTH*WGTW-1:0]  weight,
`ifdef ARB_LOCK_EN
   input  logic                   lock,
`endif
   output logic [WIDTH-1:0]       grt,
   output logic [BITW:0]          id,
   output logic [WIDTH-1:0]       pre_grt,
   output logic [BITW:0]          pre_id
);

   // Owner index and remaining credits of the current quantum.
   logic [BITW-1:0] ptr;
   logic [BITW-1:0] ptr_nxt;
   logic [WGTW-1:0] crd;
   logic [WGTW-1:0] crd_nxt;

   // Search result of the round-robin scan.
   logic            found;
   logic [BITW-1:0] win;
   logic [WGTW-1:0] win_wgt_raw;
   logic [WGTW-1:0] win_wgt;

   // Grant decision.
   logic            owner_live;
   logic            lock_hold;
   logic            hold;
   logic            pre_vld;
   logic [BITW-1:0] pre_idx;

   // Wrap a scan position back into 0..WIDTH-1. The scan never runs past
   // 2*WIDTH-1, so a single conditional subtract is enough.
   function automatic logic [BITW-1:0] wrap_idx(input int unsigned pos);
      int unsigned p;
      p = (pos >= WIDTH) ? pos - WIDTH : pos;
      return BITW'(p);
   endfunction

   // The owner is still in business while it holds the grant and keeps
   // requesting. grt is always either zero or 1<<ptr, so testing grt[ptr]
   // is the same as testing for a valid grant.
   assign owner_live = grt[ptr] & req[ptr];

`ifdef ARB_LOCK_EN
   // lock only matters while there is a live owner. With no valid grant it
   // has no effect.
   assign lock_hold = owner_live & lock;
`else
   assign lock_hold = 1'b0;
`endif

   // Keep the grant while credits remain. crd == 1 marks the last cycle of
   // the quantum, so a weight of w gives exactly w granted cycles.
   assign hold = owner_live & (lock_hold | (crd > WGTW'(1)));

   // Round-robin scan. It starts just after the owner and wraps, so the
   // owner is checked last and is granted again only when it is the sole
   // requester.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      found = 1'b0;
      win   = ptr;
      for (int i = 1; i <= WIDTH; i++) begin
         if (!found && req[wrap_idx(int'(ptr) + i)]) begin
            found = 1'b1;
            win   = wrap_idx(int'(ptr) + i);
         end
      end
   end

   // The winner's weight is sampled only when its grant starts. A weight of
   // zero still buys one cycle.
   assign win_wgt_raw = weight[win*WGTW +: WGTW];
   assign win_wgt     = (win_wgt_raw == '0) ? WGTW'(1) : win_wgt_raw;

   // Next-grant selection and next state of ptr and crd.
   always_comb begin
      pre_grt = '0;
      pre_vld = 1'b0;
      pre_idx = '0;
      ptr_nxt = ptr;
      crd_nxt = crd;
      if (hold) begin
         pre_grt = grt;
         pre_vld = 1'b1;
         pre_idx = ptr;
         if (!lock_hold) begin
            crd_nxt = crd - WGTW'(1);
         end
      end else if (found) begin
         // A fresh grant. This also covers a sole requester whose quantum
         // ran out: it wins again with reloaded credits and no gap in grt.
         pre_grt = WIDTH'(1) << win;
         pre_vld = 1'b1;
         pre_idx = win;
         ptr_nxt = win;
         crd_nxt = win_wgt;
      end
      // With no request at all, ptr and crd keep their values. crd is
      // reloaded before it is used again.
   end

   assign pre_id = {pre_vld, pre_idx};

   // Reset sets ptr to WIDTH-1, so the first scan starts at requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grt <= '0;
         id  <= '0;
         ptr <= BITW'(WIDTH - 1);
         crd <= '0;
      end else begin
         // NOTE: registered state uses non-blocking assignments, so every
         // flop samples the values from before this edge.
         grt <= pre_grt;
         id  <= pre_id;
         ptr <= ptr_nxt;
         crd <= crd_nxt;
      end
   end

endmodule

// File: tb/tb_arbiter_wrr.sv
// -----------------------------------------------------------------------------
// tb_arbiter_wrr -- self-checking bench for arbiter_wrr (WIDTH=4, WGTW=4)
//
// The bench uses a scoreboard. Each expected {grt, id} is pushed when its
// stimulus is set up, then popped and compared 1 ns after the rising edge
// that should produce it. The combinational pre_grt/pre_id outputs and the
// reset values are compared directly at chosen points.
// -----------------------------------------------------------------------------
module tb_arbiter_wrr;

   localparam int WIDTH = 4;
   localparam int WGTW  = 4;
   localparam int BITW  = 2;

   logic                  clk;
   logic                  rst_n;
   logic [WIDTH-1:0]      req;
   logic [WIDTH*WGTW-1:0] weight;
`ifdef ARB_LOCK_EN
   logic                  lock;
`endif
   logic [WIDTH-1:0]      grt;
   logic [BITW:0]         id;
   logic [WIDTH-1:0]      pre_grt;
   logic [BITW:0]         pre_id;

   typedef struct {
      logic [WIDTH-1:0] grt;
      logic [BITW:0]    id;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   arbiter_wrr #(.WIDTH(WIDTH), .WGTW(WGTW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .weight  (weight),
`ifdef ARB_LOCK_EN
      .lock    (lock),
`endif
      .grt     (grt),
      .id      (id),
      .pre_grt (pre_grt),
      .pre_id  (pre_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Push the expected grant for n consecutive edges. An index of -1 means
   // no grant is expected.
   task automatic push(input int n, input int idx);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (idx < 0) begin
            e.grt = '0;
            e.id  = '0;
         end else begin
            e.grt = WIDTH'(1) << idx;
            e.id  = {1'b1, BITW'(idx)};
         end
         sb.push_back(e);
      end
   endtask

   // Wait one rising edge, then compare the DUT against the oldest
   // scoreboard entry.
   task automatic step(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      step_no++;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check($sformatf("%s_grt@%0d", tag, step_no), 32'(grt), 32'(e.grt));
         check($sformatf("%s_id@%0d", tag, step_no), 32'(id), 32'(e.id));
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   // Assert reset mid-run. grt and id must clear without waiting for an edge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_grt"}, 32'(grt), 32'd0);
      check({tag, "_rst_id"}, 32'(id), 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      req    = 4'b1111;
      weight = 16'h2222;
`ifdef ARB_LOCK_EN
      lock   = 1'b0;
`endif

      // Reset state. Requests are present, so pre_grt already points at
      // requester 0.
      @(posedge clk);
      #1;
      check("reset_grt", 32'(grt), 32'd0);
      check("reset_id", 32'(id), 32'd0);
      check("reset_pre_grt", 32'(pre_grt), 32'h1);
      check("reset_pre_id", 32'(pre_id), 32'h4);

      // All weights 2, all requesting: two cycles each, no idle cycles.
      rst_n = 1'b1;
      push(2, 0); push(2, 1); push(2, 2); push(2, 3); push(1, 0);
      run(9, "w2");

      // Mixed weights {3,0,1,2} for idx3..0: durations 2,1,1,3 for idx 0..3.
      do_reset("mid");
      weight = 16'h3012;
      req    = 4'b1111;
      rst_n  = 1'b1;
      push(2, 0); push(1, 1); push(1, 2); push(3, 3); push(2, 0);
      run(9, "mix");

      // Sole requester 2 with weight 3: continuous grant across reloads.
      do_reset("sole");
      weight = 16'h0300;
      req    = 4'b0100;
      rst_n  = 1'b1;
      push(7, 2);
      run(7, "sole");

      // Owner 0 (weight 5) drops its request after two cycles while 2 waits.
      do_reset("drop");
      weight = 16'h1115;
      req    = 4'b0101;
      rst_n  = 1'b1;
      push(2, 0);
      run(2, "drop");
      req = 4'b0100;
      #1;
      check("drop_pre_grt", 32'(pre_grt), 32'h4);
      check("drop_pre_id", 32'(pre_id), 32'h6);
      push(2, 2);
      run(2, "drop");
      // Requester 0 comes back and gets its full quantum of 5.
      req = 4'b0101;
      push(5, 0); push(1, 2);
      run(6, "rejoin");

      // Requests vanish: pre_grt drops at once and grt clears at the edge.
      req = 4'b0000;
      #1;
      check("idle_pre_grt", 32'(pre_grt), 32'h0);
      check("idle_pre_id", 32'(pre_id), 32'h0);
      push(1, -1);
      run(1, "idle");
      // A request at an idle arbiter gives pre_grt in the same cycle.
      req = 4'b0010;
      #1;
      check("wake_pre_grt", 32'(pre_grt), 32'h2);
      check("wake_pre_id", 32'(pre_id), 32'h5);
      push(1, 1);
      run(1, "wake");

`ifdef ARB_LOCK_EN
      // Lock during owner 1's grant holds it for 10 cycles. When lock falls,
      // the one remaining credit is spent and then requester 2 gets the grant.
      do_reset("lock");
      weight = 16'h2222;
      req    = 4'b1111;
      lock   = 1'b0;
      rst_n  = 1'b1;
      push(2, 0); push(1, 1);
      run(3, "lock_pre");
      lock = 1'b1;
      push(10, 1);
      run(10, "lock_hold");
      lock = 1'b0;
      push(1, 1); push(1, 2);
      run(2, "lock_rel");
`endif

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
